// File: rtl/sram_arb_pkg.sv
// Shared types for the instruction/data SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        GNT_INST,
        GNT_DATA
    } gnt_t;

    localparam int STARVE_W = 4;
    localparam int LAT_W    = 2;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision between fetch and data with fetch starvation guard.
// Grant is combinational from the current requests; starve_q updates only on arbitration edges.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arb_en_i,
    input  logic inst_req_i,
    input  logic data_req_i,
    output logic gnt_data_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                inst_wins;

    // Data wins a tie unless fetch has already lost STARVE_MAX times in a row.
    assign inst_wins  = inst_req_i && (!data_req_i || (starve_q == STARVE_LIM));
    assign gnt_data_o = !inst_wins;

    always_comb begin
        starve_d = starve_q;
        if (arb_en_i) begin
            if (inst_wins || !inst_req_i) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and data; one transaction per RD_LAT+3 cycles.
// Requesters hold req until their one-cycle ack; all outputs are registered.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ack,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ack,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    gnt_t              gnt_q, gnt_d, pick_gnt;
    logic              pick_data, arb_go, capture;

    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic              inst_ack_q, inst_ack_d, data_ack_q, data_ack_d;

    assign arb_go   = (state_q == IDLE) && (inst_req || data_req);
    assign capture  = (state_q == WAIT) && (lat_q == '0);
    assign pick_gnt = pick_data ? GNT_DATA : GNT_INST;

    sram_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk_i      (clk),
        .rst_i      (rst),
        .arb_en_i   (arb_go),
        .inst_req_i (inst_req),
        .data_req_i (data_req),
        .gnt_data_o (pick_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            gnt_q        <= GNT_INST;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            gnt_q        <= gnt_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_go) begin
                    state_d = ISSUE;
                    gnt_d   = pick_gnt;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_INIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write enables are only ever nonzero in the single ISSUE cycle.
    always_comb begin
        mem_en_d    = arb_go;
        mem_wen_d   = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (arb_go) begin
            if (pick_gnt == GNT_DATA) begin
                mem_wen_d   = data_wen;
                mem_addr_d  = data_addr;
                mem_wdata_d = data_wdata;
            end else begin
                mem_addr_d  = inst_addr;
                mem_wdata_d = '0;
            end
        end
        inst_ack_d   = capture && (gnt_q == GNT_INST);
        data_ack_d   = capture && (gnt_q == GNT_DATA);
        inst_rdata_d = inst_ack_d ? mem_rdata : inst_rdata_q;
        data_rdata_d = data_ack_d ? mem_rdata : data_rdata_q;
    end

    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ack   = inst_ack_q;
    assign data_ack   = data_ack_q;

endmodule
